// File: rtl/gf2_poly_div_131bit_if.sv
// gf2_poly_div_131bit_if: request/result handshake bundle for the GF(2) polynomial divider
interface gf2_poly_div_131bit_if #(
  parameter int DIVIDEND_W = 131,
  parameter int DIVISOR_W  = 66
);
  localparam int QW = DIVIDEND_W - DIVISOR_W + 1;
  localparam int RW = DIVISOR_W - 1;
  logic                  in_valid;
  logic                  in_ready;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  out_valid;
  logic                  out_ready;
  logic [QW-1:0]         quotient;
  logic [RW-1:0]         remainder;
  logic                  div_err;
  logic                  busy;
  modport master(output in_valid, dividend, divisor, out_ready,
                 input in_ready, out_valid, quotient, remainder, div_err, busy);
  modport slave(input in_valid, dividend, divisor, out_ready,
                output in_ready, out_valid, quotient, remainder, div_err, busy);
endinterface

// File: rtl/gf2_poly_div_131bit.sv
// gf2_poly_div_131bit: bit-serial GF(2) long divider, one quotient bit per clock.
// Define GF2DIV_EARLY_TERM_EN to finish as soon as the remaining quotient bits are known zero.
module gf2_poly_div_131bit #(
  parameter int DIVIDEND_W = 131,
  parameter int DIVISOR_W  = 66
) (
  input logic clk,
  input logic rst,
  gf2_poly_div_131bit_if.slave s
);
  localparam int QW = DIVIDEND_W - DIVISOR_W + 1;
  localparam int RW = DIVISOR_W - 1;
  localparam int KW = $clog2(QW);
  localparam int TW = $clog2(DIVIDEND_W);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [DIVIDEND_W-1:0] w, w_nx, shifted;
  logic [DIVISOR_W-1:0] d;
  logic [QW-1:0] q, q_nx, quotient;
  logic [RW-1:0] remainder;
  logic [KW-1:0] k, sh;
  logic [TW-1:0] top;
  logic lead, early, div_err;
  assign top = TW'(DIVIDEND_W - 1) - TW'(k);
  assign sh = KW'(QW - 1) - k;
  assign lead = w[top];
  assign shifted = {{(DIVIDEND_W-DIVISOR_W){1'b0}}, d} << sh;
  // Each step clears the bit it examines, so everything above 130-k is already zero.
`ifdef GF2DIV_EARLY_TERM_EN
  assign early = w[DIVIDEND_W-1:RW] == '0;
`else
  assign early = 1'b0;
`endif
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    w_nx = w;
    q_nx = q;
    case (state)
      IDLE: state_nx = s.in_valid ? (s.divisor[DIVISOR_W-1] ? RUN : DONE) : IDLE;
      RUN: begin
        q_nx = early ? q : q | (QW'(lead) << sh);
        w_nx = (!early && lead) ? w ^ shifted : w;
        state_nx = (early || k == KW'(QW - 1)) ? DONE : RUN;
      end
      DONE: state_nx = s.out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      w <= '0;
      d <= '0;
      q <= '0;
      k <= '0;
      quotient <= '0;
      remainder <= '0;
      div_err <= 1'b0;
    end else if (state == IDLE && s.in_valid) begin
      w <= s.dividend;
      d <= s.divisor;
      q <= '0;
      k <= '0;
      if (!s.divisor[DIVISOR_W-1]) begin
        quotient <= '0;
        remainder <= '0;
        div_err <= 1'b1;
      end
    end else if (state == RUN) begin
      w <= w_nx;
      q <= q_nx;
      k <= k + 1'b1;
      if (state_nx == DONE) begin
        quotient <= q_nx;
        remainder <= w_nx[RW-1:0];
        div_err <= 1'b0;
      end
    end
  end
  assign s.in_ready = state == IDLE;
  assign s.out_valid = state == DONE;
  assign s.busy = state == RUN;
  assign s.quotient = quotient;
  assign s.remainder = remainder;
  assign s.div_err = div_err;
endmodule

// File: tb/tb_gf2_poly_div_131bit.sv
// tb_gf2_poly_div_131bit: directed and product-based checks of the GF(2) divider
module tb_gf2_poly_div_131bit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  gf2_poly_div_131bit_if bus();
  gf2_poly_div_131bit dut (.clk(clk), .rst(rst), .s(bus));
`ifdef GF2DIV_EARLY_TERM_EN
  localparam int LAT_TOP = 3;
  localparam int LAT_ZERO = 2;
`else
  localparam int LAT_TOP = 67;
  localparam int LAT_ZERO = 67;
`endif
  function automatic logic [130:0] clmul(input logic [65:0] a, input logic [65:0] b);
    logic [130:0] p = '0;
    for (int i = 0; i < 66; i++)
      if (a[i]) p ^= 131'(b) << i;
    return p;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input logic [130:0] a, input logic [65:0] b,
                        output logic [65:0] q, output logic [64:0] r, output logic e,
                        output int lat, output logic busy1);
    int n = 0;
    while (!bus.in_ready && n < 200) begin tick(); n++; end
    bus.dividend = a;
    bus.divisor = b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    busy1 = bus.busy;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin tick(); lat++; end
    q = bus.quotient;
    r = bus.remainder;
    e = bus.div_err;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    tests++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.div_err} !== 4'b1000) begin
      fails++;
      $display("FAIL reset_flags: got rdy/vld/busy/err=%b want 1000",
               {bus.in_ready, bus.out_valid, bus.busy, bus.div_err});
    end
    tests++;
    if (bus.quotient !== 66'd0 || bus.remainder !== 65'd0) begin
      fails++;
      $display("FAIL reset_data: got q=%h r=%h want 0 0", bus.quotient, bus.remainder);
    end
    rst = 1'b0;
    tick();
  endtask
  task automatic test_basic();
    logic [65:0] q;
    logic [64:0] r;
    logic e, b1;
    int lat;
    run_op(131'd1 << 130, 66'd1 << 65, q, r, e, lat, b1);
    tests++;
    if (q !== (66'd1 << 65) || r !== 65'd0 || e !== 1'b0) begin
      fails++;
      $display("FAIL top_bit: got q=%h r=%h e=%b want q=%h r=0 e=0", q, r, e, 66'd1 << 65);
    end
    tests++;
    if (lat != LAT_TOP) begin
      fails++;
      $display("FAIL top_bit_latency: got %0d want %0d", lat, LAT_TOP);
    end
    tests++;
    if (b1 !== 1'b1) begin
      fails++;
      $display("FAIL busy_in_run: got %b want 1", b1);
    end
    run_op((131'd3 << 65) | 131'd3, (66'd1 << 65) | 66'd1, q, r, e, lat, b1);
    tests++;
    if (q !== 66'd3 || r !== 65'd0 || e !== 1'b0) begin
      fails++;
      $display("FAIL exact_div: got q=%h r=%h e=%b want q=3 r=0 e=0", q, r, e);
    end
    run_op((131'd3 << 65) | 131'd2, (66'd1 << 65) | 66'd1, q, r, e, lat, b1);
    tests++;
    if (q !== 66'd3 || r !== 65'd1 || e !== 1'b0) begin
      fails++;
      $display("FAIL rem_one: got q=%h r=%h e=%b want q=3 r=1 e=0", q, r, e);
    end
    tests++;
    if (lat != 67) begin
      fails++;
      $display("FAIL rem_one_latency: got %0d want 67", lat);
    end
  endtask
  task automatic test_div_err();
    logic [65:0] q;
    logic [64:0] r;
    logic e, b1;
    int lat;
    run_op({3'b101, {4{32'hdead_beef}}}, 66'h1, q, r, e, lat, b1);
    tests++;
    if (q !== 66'd0 || r !== 65'd0 || e !== 1'b1) begin
      fails++;
      $display("FAIL div_err: got q=%h r=%h e=%b want q=0 r=0 e=1", q, r, e);
    end
    tests++;
    if (lat != 1 || b1 !== 1'b0) begin
      fails++;
      $display("FAIL div_err_timing: got lat=%0d busy=%b want lat=1 busy=0", lat, b1);
    end
  endtask
  task automatic test_random();
    logic [65:0] q, a, b;
    logic [64:0] r, rr;
    logic [95:0] t;
    logic e, b1;
    int lat;
    for (int i = 0; i < 40; i++) begin
      t = {$urandom, $urandom, $urandom};
      a = t[65:0];
      t = {$urandom, $urandom, $urandom};
      b = t[65:0] | (66'd1 << 65);
      t = {$urandom, $urandom, $urandom};
      rr = t[64:0];
      run_op(clmul(a, b) ^ 131'(rr), b, q, r, e, lat, b1);
      tests++;
      if (q !== a || r !== rr || e !== 1'b0) begin
        fails++;
        $display("FAIL random_%0d: got q=%h r=%h e=%b want q=%h r=%h e=0", i, q, r, e, a, rr);
      end
    end
  endtask
  task automatic test_backpressure();
    logic [65:0] q0;
    logic [64:0] r0;
    int n = 0;
    bus.dividend = (131'd3 << 65) | 131'd2;
    bus.divisor = (66'd1 << 65) | 66'd1;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    while (!bus.out_valid && n < 200) begin tick(); n++; end
    q0 = bus.quotient;
    r0 = bus.remainder;
    tests++;
    if (q0 !== 66'd3 || r0 !== 65'd1) begin
      fails++;
      $display("FAIL bp_result: got q=%h r=%h want q=3 r=1", q0, r0);
    end
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = (c == 4);
      bus.dividend = 131'd1 << 130;
      bus.divisor = 66'h1;
      tick();
      tests++;
      if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b100 || bus.quotient !== 66'd3 ||
          bus.remainder !== 65'd1 || bus.div_err !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold_%0d: got vld/rdy/busy=%b q=%h r=%h e=%b want 100 q=3 r=1 e=0",
                 c, {bus.out_valid, bus.in_ready, bus.busy}, bus.quotient, bus.remainder, bus.div_err);
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    tests++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01 || bus.quotient !== 66'd3 || bus.remainder !== 65'd1) begin
      fails++;
      $display("FAIL bp_release: got vld/rdy=%b q=%h r=%h want 01 q=3 r=1",
               {bus.out_valid, bus.in_ready}, bus.quotient, bus.remainder);
    end
  endtask
  task automatic test_rst_mid();
    logic [65:0] q;
    logic [64:0] r;
    logic e, b1;
    int lat;
    bus.dividend = 131'd1 << 130;
    bus.divisor = 66'd1 << 65;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (30) tick();
    tests++;
    if (bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_busy: got %b want 1", bus.busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b010 || bus.quotient !== 66'd0) begin
      fails++;
      $display("FAIL rst_mid_abort: got vld/rdy/busy=%b q=%h want 010 q=0",
               {bus.out_valid, bus.in_ready, bus.busy}, bus.quotient);
    end
    run_op((131'd3 << 65) | 131'd3, (66'd1 << 65) | 66'd1, q, r, e, lat, b1);
    tests++;
    if (q !== 66'd3 || r !== 65'd0 || e !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_after: got q=%h r=%h e=%b want q=3 r=0 e=0", q, r, e);
    end
  endtask
  task automatic test_zero_dividend();
    logic [65:0] q;
    logic [64:0] r;
    logic e, b1;
    int lat;
    run_op(131'd0, (66'd1 << 65) | 66'd5, q, r, e, lat, b1);
    tests++;
    if (q !== 66'd0 || r !== 65'd0 || e !== 1'b0) begin
      fails++;
      $display("FAIL zero_div: got q=%h r=%h e=%b want 0 0 0", q, r, e);
    end
    tests++;
    if (lat != LAT_ZERO) begin
      fails++;
      $display("FAIL zero_latency: got %0d want %0d", lat, LAT_ZERO);
    end
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    test_reset();
    test_basic();
    test_div_err();
    test_random();
    test_backpressure();
    test_rst_mid();
    test_zero_dividend();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
